// File: rtl/noc_params.sv
// Shared NoC configuration and the per-VC credit FSM state type used by the
// upstream credit tracker.
package noc_params;

    localparam int unsigned VC_NUM      = 2;
    localparam int unsigned PORT_NUM    = 5;
    localparam int unsigned VC_SIZE     = $clog2(VC_NUM);
    localparam int unsigned VC_TOTAL    = PORT_NUM * VC_NUM;
    localparam int unsigned BUFFER_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } vc_credit_state_t;

    // Credit counters must hold the full range 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Single downstream-VC bookkeeping: IDLE/ACTIVE/DRAIN FSM plus credit counter.
// Optional CREDIT_CHECK_EN adds a sticky protocol-error flag.
module vc_credit_counter
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = noc_params::BUFFER_SIZE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_alloc,
    input  logic i_flit,
    input  logic i_tail,
    input  logic i_credit,
    output logic o_idle,
`ifdef CREDIT_CHECK_EN
    output logic o_err,
`endif
    output logic o_full
);

    localparam int unsigned CNT_W = credit_width(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_SIZE);

    vc_credit_state_t   r_state;
    vc_credit_state_t   w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_flit_acc;
    logic               w_credit_acc;

    assign w_flit_acc   = i_flit && (r_state == ACTIVE) && (r_count != '0);
    assign w_credit_acc = i_credit && (r_count != CNT_MAX);
    assign w_count_next = r_count - CNT_W'(w_flit_acc) + CNT_W'(w_credit_acc);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_alloc) begin
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_flit_acc && i_tail) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Release only once every downstream slot has been returned.
                if (w_count_next == CNT_MAX) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= CNT_MAX;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    assign o_idle = (r_state == IDLE);
    assign o_full = (r_count == '0);

`ifdef CREDIT_CHECK_EN
    logic r_err;
    logic w_violation;

    assign w_violation = (i_alloc && (r_state != IDLE))
                      || (i_flit && !((r_state == ACTIVE) && (r_count != '0)))
                      || (i_credit && (r_count == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_violation) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: rtl/vc_credit_tracker.sv
// Per-output-port tracker of downstream VC state and credits; one counter per VC.
// Define CREDIT_CHECK_EN to add the sticky protocol_error_o output.
module vc_credit_tracker
    import noc_params::*;
#(
    parameter int unsigned PORT_NUM    = noc_params::PORT_NUM,
    parameter int unsigned VC_NUM      = noc_params::VC_NUM,
    parameter int unsigned VC_TOTAL    = PORT_NUM * VC_NUM,
    parameter int unsigned BUFFER_SIZE = noc_params::BUFFER_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VC_TOTAL-1:0] vc_allocated_i,
    input  logic [VC_TOTAL-1:0] flit_sent_i,
    input  logic [VC_TOTAL-1:0] tail_sent_i,
    input  logic [VC_TOTAL-1:0] credit_i,
`ifdef CREDIT_CHECK_EN
    output logic [VC_TOTAL-1:0] protocol_error_o,
`endif
    output logic [VC_TOTAL-1:0] idle_downstream_vc_o,
    output logic [VC_TOTAL-1:0] is_full_o
);

    for (genvar g = 0; g < VC_TOTAL; g++) begin : g_vc
        vc_credit_counter #(
            .BUFFER_SIZE (BUFFER_SIZE)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .i_alloc  (vc_allocated_i[g]),
            .i_flit   (flit_sent_i[g]),
            .i_tail   (tail_sent_i[g]),
            .i_credit (credit_i[g]),
            .o_idle   (idle_downstream_vc_o[g]),
`ifdef CREDIT_CHECK_EN
            .o_err    (protocol_error_o[g]),
`endif
            .o_full   (is_full_o[g])
        );
    end

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Self-checking bench for vc_credit_tracker: directed scenarios plus randomized
// traffic checked against a per-VC behavioural model.
module tb_vc_credit_tracker;

    localparam int NV = 10;
    localparam int BS = 8;
    localparam int S_IDLE = 0;
    localparam int S_ACTIVE = 1;
    localparam int S_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NV-1:0] vc_allocated_i = '0;
    logic [NV-1:0] flit_sent_i = '0;
    logic [NV-1:0] tail_sent_i = '0;
    logic [NV-1:0] credit_i = '0;
    logic [NV-1:0] idle_downstream_vc_o;
    logic [NV-1:0] is_full_o;
`ifdef CREDIT_CHECK_EN
    logic [NV-1:0] protocol_error_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: protocol state, credits held and sticky error per VC.
    int m_st  [NV];
    int m_cnt [NV];
    bit m_err [NV];

    always #5 clk = ~clk;

    vc_credit_tracker dut (
        .clk                  (clk),
        .rst                  (rst),
        .vc_allocated_i       (vc_allocated_i),
        .flit_sent_i          (flit_sent_i),
        .tail_sent_i          (tail_sent_i),
        .credit_i             (credit_i),
`ifdef CREDIT_CHECK_EN
        .protocol_error_o     (protocol_error_o),
`endif
        .idle_downstream_vc_o (idle_downstream_vc_o),
        .is_full_o            (is_full_o)
    );

    function automatic void model_update(input logic r, input logic [NV-1:0] a,
                                         input logic [NV-1:0] f, input logic [NV-1:0] t,
                                         input logic [NV-1:0] c);
        for (int v = 0; v < NV; v++) begin
            if (r) begin
                m_st[v] = S_IDLE;
                m_cnt[v] = BS;
                m_err[v] = 1'b0;
            end else begin
                bit can_send;
                bit fa;
                bit ca;
                int nc;
                can_send = (m_st[v] == S_ACTIVE) && (m_cnt[v] > 0);
                fa = f[v] && can_send;
                ca = c[v] && (m_cnt[v] < BS);
                if ((a[v] && m_st[v] != S_IDLE) || (f[v] && !can_send) || (c[v] && !ca))
                    m_err[v] = 1'b1;
                nc = m_cnt[v] - int'(fa) + int'(ca);
                if (m_st[v] == S_IDLE && a[v]) m_st[v] = S_ACTIVE;
                else if (m_st[v] == S_ACTIVE && fa && t[v]) m_st[v] = S_DRAIN;
                else if (m_st[v] == S_DRAIN && nc == BS) m_st[v] = S_IDLE;
                m_cnt[v] = nc;
            end
        end
    endfunction

    function automatic logic [NV-1:0] exp_idle();
        logic [NV-1:0] e;
        for (int v = 0; v < NV; v++) e[v] = (m_st[v] == S_IDLE);
        return e;
    endfunction

    function automatic logic [NV-1:0] exp_full();
        logic [NV-1:0] e;
        for (int v = 0; v < NV; v++) e[v] = (m_cnt[v] == 0);
        return e;
    endfunction

    function automatic logic [NV-1:0] exp_err();
        logic [NV-1:0] e;
        for (int v = 0; v < NV; v++) e[v] = m_err[v];
        return e;
    endfunction

    // Drive one cycle of stimulus; outputs are stable 1 time unit after the edge.
    task automatic step(input logic r, input logic [NV-1:0] a, input logic [NV-1:0] f,
                        input logic [NV-1:0] t, input logic [NV-1:0] c);
        @(negedge clk);
        rst = r;
        vc_allocated_i = a;
        flit_sent_i = f;
        tail_sent_i = t;
        credit_i = c;
        @(posedge clk);
        model_update(r, a, f, t, c);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, '0, '0, '0, '0);
        step(1'b0, '0, '0, '0, '0);
        n_checks++;
        if (idle_downstream_vc_o !== 10'h3FF) begin
            n_errors++;
            $display("FAIL reset_idle: got %h expected %h", idle_downstream_vc_o, 10'h3FF);
        end
        n_checks++;
        if (is_full_o !== 10'h000) begin
            n_errors++;
            $display("FAIL reset_full: got %h expected %h", is_full_o, 10'h000);
        end
`ifdef CREDIT_CHECK_EN
        n_checks++;
        if (protocol_error_o !== 10'h000) begin
            n_errors++;
            $display("FAIL reset_err: got %h expected %h", protocol_error_o, 10'h000);
        end
`endif
    endtask

    task automatic test_full_packet();
        bit bad_idle;
        bit bad_full;
        step(1'b1, '0, '0, '0, '0);
        step(1'b0, 10'h008, '0, '0, '0);
        n_checks++;
        if (idle_downstream_vc_o[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL pkt_grant_idle: got %b expected 0", idle_downstream_vc_o[3]);
        end
        bad_full = 1'b0;
        for (int i = 1; i <= BS; i++) begin
            step(1'b0, '0, 10'h008, (i == BS) ? 10'h008 : 10'h000, '0);
            if (i < BS && is_full_o[3] !== 1'b0) bad_full = 1'b1;
        end
        n_checks++;
        if (bad_full) begin
            n_errors++;
            $display("FAIL pkt_early_full: got 1 before 8th flit expected 0");
        end
        n_checks++;
        if (is_full_o[3] !== 1'b1 || idle_downstream_vc_o[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL pkt_drain: got full=%b idle=%b expected full=1 idle=0",
                     is_full_o[3], idle_downstream_vc_o[3]);
        end
        bad_idle = 1'b0;
        for (int i = 1; i <= BS; i++) begin
            step(1'b0, '0, '0, '0, 10'h008);
            if (i < BS && idle_downstream_vc_o[3] !== 1'b0) bad_idle = 1'b1;
        end
        n_checks++;
        if (bad_idle) begin
            n_errors++;
            $display("FAIL pkt_early_idle: got idle before last credit expected 0");
        end
        n_checks++;
        if (idle_downstream_vc_o[3] !== 1'b1 || is_full_o[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL pkt_release: got idle=%b full=%b expected idle=1 full=0",
                     idle_downstream_vc_o[3], is_full_o[3]);
        end
    endtask

    task automatic test_simultaneous();
        bit bad;
        step(1'b1, '0, '0, '0, '0);
        step(1'b0, 10'h020, '0, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 10'h020, '0, '0);
        step(1'b0, '0, 10'h020, '0, 10'h020);
        n_checks++;
        if (is_full_o[5] !== 1'b0 || idle_downstream_vc_o[5] !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_outputs: got full=%b idle=%b expected full=0 idle=0",
                     is_full_o[5], idle_downstream_vc_o[5]);
        end
        // Count must still be 4: full appears exactly on the 4th further flit.
        bad = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, '0, 10'h020, '0, '0);
            if (is_full_o[5] !== 1'b0) bad = 1'b1;
        end
        step(1'b0, '0, 10'h020, '0, '0);
        n_checks++;
        if (bad || is_full_o[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_count: got early=%b full=%b expected early=0 full=1",
                     bad, is_full_o[5]);
        end
    endtask

    task automatic test_head_tail();
        step(1'b1, '0, '0, '0, '0);
        step(1'b0, 10'h001, '0, '0, '0);
        step(1'b0, '0, 10'h001, 10'h001, '0);
        step(1'b0, '0, '0, '0, '0);
        n_checks++;
        if (idle_downstream_vc_o[0] !== 1'b0 || is_full_o[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL ht_drain: got idle=%b full=%b expected idle=0 full=0",
                     idle_downstream_vc_o[0], is_full_o[0]);
        end
        step(1'b0, '0, '0, '0, 10'h001);
        n_checks++;
        if (idle_downstream_vc_o[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL ht_release: got idle=%b expected 1", idle_downstream_vc_o[0]);
        end
    endtask

    task automatic test_violations();
        bit bad;
        step(1'b1, '0, '0, '0, '0);
        step(1'b0, '0, 10'h004, '0, 10'h002);
        n_checks++;
        if (idle_downstream_vc_o !== 10'h3FF || is_full_o !== 10'h000) begin
            n_errors++;
            $display("FAIL viol_ignored: got idle=%h full=%h expected idle=3ff full=000",
                     idle_downstream_vc_o, is_full_o);
        end
`ifdef CREDIT_CHECK_EN
        n_checks++;
        if (protocol_error_o !== 10'h006) begin
            n_errors++;
            $display("FAIL viol_err_set: got %h expected %h", protocol_error_o, 10'h006);
        end
`endif
        // Both VCs must still hold exactly 8 credits.
        step(1'b0, 10'h006, '0, '0, '0);
        bad = 1'b0;
        for (int i = 1; i <= BS; i++) begin
            step(1'b0, '0, 10'h006, '0, '0);
            if (i < BS && is_full_o[2:1] !== 2'b00) bad = 1'b1;
        end
        n_checks++;
        if (bad || is_full_o[2:1] !== 2'b11) begin
            n_errors++;
            $display("FAIL viol_count: got early=%b full=%b expected early=0 full=11",
                     bad, is_full_o[2:1]);
        end
`ifdef CREDIT_CHECK_EN
        n_checks++;
        if (protocol_error_o !== 10'h006) begin
            n_errors++;
            $display("FAIL viol_err_sticky: got %h expected %h", protocol_error_o, 10'h006);
        end
        step(1'b1, '0, '0, '0, '0);
        n_checks++;
        if (protocol_error_o !== 10'h000) begin
            n_errors++;
            $display("FAIL viol_err_clear: got %h expected %h", protocol_error_o, 10'h000);
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        bit bad;
        step(1'b1, '0, '0, '0, '0);
        step(1'b0, 10'h080, '0, '0, '0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 10'h080, '0, '0);
        step(1'b1, '0, 10'h080, '0, '0);
        n_checks++;
        if (idle_downstream_vc_o[7] !== 1'b1 || is_full_o[7] !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_out: got idle=%b full=%b expected idle=1 full=0",
                     idle_downstream_vc_o[7], is_full_o[7]);
        end
        step(1'b0, 10'h080, '0, '0, '0);
        bad = 1'b0;
        for (int i = 1; i <= BS; i++) begin
            step(1'b0, '0, 10'h080, '0, '0);
            if (i < BS && is_full_o[7] !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || is_full_o[7] !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_count: got early=%b full=%b expected early=0 full=1",
                     bad, is_full_o[7]);
        end
    endtask

    task automatic test_random();
        logic [NV-1:0] a, f, t, c;
        int bad_cycles;
        bad_cycles = 0;
        step(1'b1, '0, '0, '0, '0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int v = 0; v < NV; v++) begin
                a[v] = ($urandom_range(0, 5) == 0);
                f[v] = ($urandom_range(0, 1) == 0);
                t[v] = ($urandom_range(0, 3) == 0);
                c[v] = ($urandom_range(0, 2) == 0);
            end
            step(($urandom_range(0, 199) == 0), a, f, t, c);
            n_checks++;
            if (idle_downstream_vc_o !== exp_idle() || is_full_o !== exp_full()) begin
                n_errors++;
                if (bad_cycles < 5)
                    $display("FAIL rand_cycle%0d: got idle=%h full=%h expected idle=%h full=%h",
                             cyc, idle_downstream_vc_o, is_full_o, exp_idle(), exp_full());
                bad_cycles++;
            end
`ifdef CREDIT_CHECK_EN
            n_checks++;
            if (protocol_error_o !== exp_err()) begin
                n_errors++;
                $display("FAIL rand_err%0d: got %h expected %h", cyc, protocol_error_o,
                         exp_err());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_simultaneous();
        test_head_tail();
        test_violations();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vc_credit_tracker.md
Name: vc_credit_tracker

Overview:
- Upstream-side, per-output-port bookkeeping of downstream VC state; the counterpart of the VC allocator.
- Receives allocation grants, flit departures and returned credits from the downstream router.
- Produces idle_downstream_vc_o, which the allocator consumes to re-mark downstream VCs available.
- Produces is_full_o for the switch allocator to block flits toward VCs with no buffer space.

Parameters:
VC_TOTAL, 10, total downstream VCs (PORT_NUM*VC_NUM), index = port*VC_NUM + vc
PORT_NUM, 5, output ports
VC_NUM, 2, VCs per port
BUFFER_SIZE, 8, flit slots per downstream VC buffer = initial credits

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
vc_allocated_i  in  VC_TOTAL  pulse: downstream VC granted to an upstream VC this cycle
flit_sent_i  in  VC_TOTAL  flit forwarded to that downstream VC this cycle
tail_sent_i  in  VC_TOTAL  qualifies flit_sent_i: flit is a tail (or head-tail)
credit_i  in  VC_TOTAL  one slot freed in downstream buffer this cycle
idle_downstream_vc_o  out  VC_TOTAL  VC in IDLE state
is_full_o  out  VC_TOTAL  credit count == 0

Behaviour:
- One independent instance of state and counter per VC.
- Counter width is $clog2(BUFFER_SIZE+1).
- States per VC: IDLE, ACTIVE, DRAIN.
- Reset (any cycle, including mid-packet):
  - all VCs go to IDLE with count = BUFFER_SIZE;
  - idle_downstream_vc_o all 1, is_full_o all 0.
- Count update each cycle: next = count - (flit_sent_i accepted) + (credit_i accepted).
  - Simultaneous flit and credit: count unchanged.
  - flit_sent_i when count==0: ignored, no underflow.
  - credit_i when count==BUFFER_SIZE: ignored, no overflow.
- Flit acceptance: flit_sent_i is accepted only in ACTIVE with count>0; otherwise ignored. credit_i is accepted in any state.
- Transitions:
  - IDLE -> ACTIVE on vc_allocated_i. vc_allocated_i in ACTIVE or DRAIN is ignored.
  - ACTIVE -> DRAIN on an accepted flit_sent_i & tail_sent_i. Single-flit packets follow the same path.
  - DRAIN -> IDLE when next count == BUFFER_SIZE; checked in DRAIN only.
  - Allocation in the same cycle as the DRAIN->IDLE transition is ignored; the allocator never grants a non-idle VC.
- Latency:
  - All outputs are Moore, decoded from registers only.
  - An event in cycle N is reflected on the outputs in N+1.
  - Grant in N -> idle_downstream_vc_o low in N+1.
  - Last credit in N -> idle high in N+1.
- tail_sent_i without flit_sent_i has no effect.

Optional Feature:
CREDIT_CHECK_EN
- Defined:
  - adds output protocol_error_o [VC_TOTAL], sticky, cleared only by rst;
  - a bit sets on any ignored event: grant while not IDLE, flit while not ACTIVE or count==0, credit at count==BUFFER_SIZE.
- Undefined: port and logic absent; violations are silently dropped as described above.

Decomposition:
- noc_params package holds:
  - BUFFER_SIZE;
  - typedef enum vc_credit_state_t {IDLE, ACTIVE, DRAIN};
  - the existing VC_NUM, PORT_NUM, VC_SIZE.
- Sub-module vc_credit_counter: single-VC FSM plus counter, instantiated VC_TOTAL times via generate. The top level only wires the bit slices.

Test Plan:
- Reset, no stimulus -> idle_downstream_vc_o=10'h3FF, is_full_o=0, all counts 8.
- Allocate VC3 at N; send 8 flits (tail on 8th) with no credits; return 8 credits:
  - idle[3]=0 from N+1;
  - is_full_o[3]=1 after the 8th flit;
  - state DRAIN;
  - idle[3]=1 the cycle after the 8th credit.
- VC5 ACTIVE, count 4, flit_sent and credit in the same cycle -> count stays 4; is_full and idle unchanged.
- Head-tail on VC0: allocate, then one flit with tail_sent=1, credit 2 cycles later -> ACTIVE, DRAIN, IDLE; idle[0] high 1 cycle after the credit.
- Violations:
  - extra credit at count 8 -> count stays 8;
  - flit on an IDLE VC -> ignored;
  - with CREDIT_CHECK_EN, the matching protocol_error_o bit latches 1 until rst.
- rst asserted while VC7 is ACTIVE with count 2 -> next cycle idle[7]=1, is_full[7]=0, count 8.
